// File: rtl/gtp_rx.sv
// rtl/gtp_rx.sv - GTP/Aurora framed-packet receiver with CRC-32 check and packet RAM writes
//
// Parses HEAD, GTXID, LENGTH, DATA x N, CRC, END from a 32-bit stream without back-pressure.
// Ports:
//   log_clk, log_rst_n            clock, asynchronous active-low reset
//   m_axi_rx_tdata/tkeep/tvalid/tlast   RX stream (tkeep ignored)
//   rx_packet_addra/data/wren     registered packet RAM write port
//   rx_packet_gtxid/head          GTXID and LENGTH word of the last good packet
//   rx_packet_done/rx_crc_err/rx_frame_err   one-cycle status pulses
//   crc_data                      running CRC register

module gtp_rx #(
    parameter logic [31:0] HEAD_WORD   = 32'h0000FFBC,
    parameter logic [31:0] END_WORD    = 32'h0000FFBD,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic [31:0] m_axi_rx_tdata,
    input  logic [3:0]  m_axi_rx_tkeep,
    input  logic        m_axi_rx_tvalid,
    input  logic        m_axi_rx_tlast,
    output logic [7:0]  rx_packet_addra,
    output logic [31:0] rx_packet_data,
    output logic        rx_packet_wren,
    output logic [31:0] rx_packet_gtxid,
    output logic [31:0] rx_packet_head,
    output logic        rx_packet_done,
    output logic        rx_crc_err,
    output logic        rx_frame_err,
    output logic [31:0] crc_data
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_GTXID, S_LENGTH, S_DATA, S_CHECK, S_END, S_DROP
    } state_t;

    state_t      state_q;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] gtxid_tmp_q;
    logic [31:0] head_tmp_q;
    logic [7:0]  rem_q;
    logic [7:0]  addr_q;
    logic        crc_ok_q;
    logic [15:0] tmo_q;
    logic [7:0]  addra_q;
    logic [31:0] data_q;
    logic        wren_q;
    logic [31:0] gtxid_q;
    logic [31:0] head_q;
    logic        done_q;
    logic        crc_err_q;
    logic        frame_err_q;

    // The link always drives tkeep to all ones, so it carries no information here.
    logic unused_tkeep;
    assign unused_tkeep = ^m_axi_rx_tkeep;

    // Parallel CRC-32, data MSB first, no reflection; matches the transmitter's nextCRC32_D32.
    function automatic logic [31:0] next_crc32_d32(input logic [31:0] d, input logic [31:0] c);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    assign crc_d = next_crc32_d32(m_axi_rx_tdata, crc_q);

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q     <= S_IDLE;
            crc_q       <= CRC_INIT;
            gtxid_tmp_q <= '0;
            head_tmp_q  <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            crc_ok_q    <= 1'b0;
            tmo_q       <= '0;
            addra_q     <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            gtxid_q     <= '0;
            head_q      <= '0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wren_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == S_IDLE) begin
                crc_q <= CRC_INIT;
                tmo_q <= '0;
            end

            if (m_axi_rx_tvalid) begin
                tmo_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (m_axi_rx_tdata == HEAD_WORD && !m_axi_rx_tlast) begin
                            state_q <= S_GTXID;
                        end
                    end
                    S_GTXID: begin
                        if (m_axi_rx_tlast) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            gtxid_tmp_q <= m_axi_rx_tdata;
                            crc_q       <= crc_d;
                            state_q     <= S_LENGTH;
                        end
                    end
                    S_LENGTH: begin
                        if (m_axi_rx_tlast) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            head_tmp_q <= m_axi_rx_tdata;
                            crc_q      <= crc_d;
                            rem_q      <= (m_axi_rx_tdata[7:0] == 8'd0) ? 8'd1 : m_axi_rx_tdata[7:0];
                            // Single-word packets with LENGTH 0x0001 land at address 0;
                            // otherwise a zero base is remapped to 1.
                            if (m_axi_rx_tdata[15:0] == 16'h0001) begin
                                addr_q <= 8'd0;
                            end else if (m_axi_rx_tdata[15:8] == 8'd0) begin
                                addr_q <= 8'd1;
                            end else begin
                                addr_q <= m_axi_rx_tdata[15:8];
                            end
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (m_axi_rx_tlast) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            wren_q  <= 1'b1;
                            addra_q <= addr_q;
                            data_q  <= m_axi_rx_tdata;
                            addr_q  <= addr_q + 8'd1;
                            crc_q   <= crc_d;
                            rem_q   <= rem_q - 8'd1;
                            if (rem_q == 8'd1) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (m_axi_rx_tlast) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            crc_ok_q <= (m_axi_rx_tdata == crc_q);
                            state_q  <= S_END;
                        end
                    end
                    S_END: begin
                        if (m_axi_rx_tdata == END_WORD && m_axi_rx_tlast) begin
                            if (crc_ok_q) begin
                                done_q  <= 1'b1;
                                gtxid_q <= gtxid_tmp_q;
                                head_q  <= head_tmp_q;
                            end else begin
                                crc_err_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= m_axi_rx_tlast ? S_IDLE : S_DROP;
                        end
                    end
                    S_DROP: begin
                        if (m_axi_rx_tlast) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE && state_q != S_DROP) begin
                // Idle cycles inside a packet; abort once the link has been silent too long.
                if (tmo_q == TIMEOUT_CYC - 16'd1) begin
                    frame_err_q <= 1'b1;
                    tmo_q       <= '0;
                    state_q     <= S_IDLE;
                end else begin
                    tmo_q <= tmo_q + 16'd1;
                end
            end
        end
    end

    assign rx_packet_addra = addra_q;
    assign rx_packet_data  = data_q;
    assign rx_packet_wren  = wren_q;
    assign rx_packet_gtxid = gtxid_q;
    assign rx_packet_head  = head_q;
    assign rx_packet_done  = done_q;
    assign rx_crc_err      = crc_err_q;
    assign rx_frame_err    = frame_err_q;
    assign crc_data        = crc_q;

endmodule
